csa16_mw_addsub_sched: RTL and testbench
========================================

// Module: csa16_mw_addsub_sched
// PURPOSE
//  Scheduler for one shared 16-bit carry-select adder (sum = a + b + cin; cout).
//  Arbitrates two requesters round-robin and runs multi-word add/sub (up to MAX_WORDS x 16 bit),
//  chaining the carry word by word. Sits between the requesters and the external adder instance.
//  The adder is combinational and is driven directly from this block's adder_* ports.
// PARAMETERS
//  W          16  adder / data word width (fixed to 16 for the csa16 datapath)
//  MAX_WORDS  8   maximum words per transaction
//  LW         3   length field width, equal to clog2(MAX_WORDS)
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous, active-high reset
//  req         in   2       request, one bit per requester (bit0 = R0, bit1 = R1)
//  req_sub     in   2       per requester: 1 = subtract (a-b), 0 = add
//  req_len     in   2*LW    per requester: word count minus 1 (0 means 1 word)
//  gnt         out  2       one-hot grant, held for the whole transaction
//  in_valid    in   1       operand beat valid (from the granted requester)
//  in_a        in   W       operand A word, LS word first
//  in_b        in   W       operand B word
//  in_ready    out  1       operand beat accepted when in_valid & in_ready
//  out_valid   out  1       result beat valid
//  out_sum     out  W       result word
//  out_last    out  1       marks the final result word
//  out_carry   out  1       final carry (add) or borrow (sub); valid only with out_last
//  out_ready   in   1       result sink ready
//  busy        out  1       high in GRANT, RUN and DRAIN
//  adder_a     out  W       to adder input a
//  adder_b     out  W       to adder input b
//  adder_cin   out  1       to adder carry-in
//  adder_sum   in   W       from adder sum
//  adder_cout  in   1       from adder carry-out
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; round-robin pointer rr = R0 first; carry reg 0.
//  FSM:
//   - IDLE -> GRANT when |req. If both request, grant rr; otherwise grant the single requester.
//   - GRANT (1 cycle): latch sub and len of the winner; gnt asserted; cnt = 0; creg = sub.
//   - GRANT -> RUN.
//   - RUN: in_ready = !out_valid | out_ready (1-entry output register, full throughput).
//   - RUN -> DRAIN on the fire of beat cnt == len.
//   - DRAIN: in_ready = 0; waits for the last out handshake.
//   - DRAIN -> IDLE on the last out handshake. Toggle rr to the non-granted requester. gnt = 0.
//   - A RUN-state out handshake with out_last also leaves via DRAIN (same cycle exit allowed).
//  Datapath:
//   - adder_a = in_a.
//   - adder_b = sub ? ~in_b : in_b.
//   - adder_cin = creg.
//   - adder_* are driven combinationally in RUN. They are 0 outside RUN.
//  On in fire:
//   - out_sum <= adder_sum; creg <= adder_cout; cnt <= cnt + 1.
//   - out_last <= (cnt == len).
//   - out_carry <= sub ? ~adder_cout : adder_cout when last, else 0.
//   - out_valid <= 1.
//  Output: out_valid is cleared on out_ready unless a new beat fires the same cycle.
//   - out_* stay stable while out_valid & !out_ready.
//  Latency: result word k appears 1 cycle after operand beat k fires.
//   - Request-to-first-in_ready is 2 cycles (IDLE -> GRANT -> RUN).
//  Boundaries:
//   - len = 0: single-word transaction; out_last is set on the first beat.
//   - Modular wrap: out_sum wraps mod 2^W; overflow is reported only through out_carry on the last word.
//   - req or req_len changing after GRANT is ignored. Dropping req mid-transaction does not abort.
//   - in_valid outside RUN is ignored (in_ready = 0).
//   - Simultaneous events: a new req arriving in the DRAIN->IDLE cycle is granted from IDLE next cycle (no back-to-back GRANT).
//   - rst mid-transaction aborts immediately: every output returns to its reset value next cycle; partial results are discarded.
// TESTING
//  1. R0 add, len=0, a=FFFF, b=0001, out_ready=1 -> out_sum=0000, out_last=1, out_carry=1, gnt=01 for 3 cycles.
//  2. R1 sub, len=1, words (0000,0001) - (0001,0000) -> out_sum 0xFFFF then 0x0000, out_carry=0 (no borrow).
//  3. R0 and R1 request together twice -> first grant R0, then R1 (rr toggles); never both granted.
//  4. 4-word add with out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled; out_sum held stable; no beat lost or duplicated.
//  5. rst asserted during RUN of a 4-word job -> next cycle busy=0, gnt=00, out_valid=0; a new R1 request then completes normally.
//  6. Random 1..8-word add/sub against a reference model -> all words and carry/borrow match.

Source files
------------

// File: rtl/csa16_mw_addsub_sched.sv
// Round-robin scheduler for one shared 16-bit carry-select adder.
// Runs multi-word add/sub by chaining the carry through the adder, LS word first.
module csa16_mw_addsub_sched #(
   parameter int W         = 16,
   parameter int MAX_WORDS = 8,
   parameter int LW        = $clog2(MAX_WORDS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req,
   input  logic [1:0]      req_sub,
   input  logic [2*LW-1:0] req_len,
   output logic [1:0]      gnt,
   input  logic            in_valid,
   input  logic [W-1:0]    in_a,
   input  logic [W-1:0]    in_b,
   output logic            in_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_sum,
   output logic            out_last,
   output logic            out_carry,
   input  logic            out_ready,
   output logic            busy,
   output logic [W-1:0]    adder_a,
   output logic [W-1:0]    adder_b,
   output logic            adder_cin,
   input  logic [W-1:0]    adder_sum,
   input  logic            adder_cout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    r_gnt;
   logic          r_rr;
   logic          r_win;
   logic          r_sub;
   logic          r_creg;
   logic [LW-1:0] r_len;
   logic [LW-1:0] r_cnt;
   logic          r_ov;
   logic [W-1:0]  r_sum;
   logic          r_last;
   logic          r_carry;

   logic          w_run;
   logic          w_fire;
   logic          w_ofire;
   logic          w_beat_last;
   logic          w_pick;

   assign w_run       = (r_state == S_RUN);
   assign in_ready    = w_run & (~r_ov | out_ready);
   assign w_fire      = in_valid & in_ready;
   assign w_ofire     = r_ov & out_ready;
   assign w_beat_last = (r_cnt == r_len);
   // both requesting: the pointer decides; otherwise the lone requester wins
   assign w_pick      = (req == 2'b11) ? r_rr : req[1];

   assign adder_a   = w_run ? in_a : '0;
   assign adder_b   = w_run ? (r_sub ? ~in_b : in_b) : '0;
   assign adder_cin = w_run & r_creg;

   assign gnt       = r_gnt;
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_ov;
   assign out_sum   = r_sum;
   assign out_last  = r_last;
   assign out_carry = r_carry;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_gnt   <= 2'b00;
         r_rr    <= 1'b0;
         r_win   <= 1'b0;
         r_sub   <= 1'b0;
         r_creg  <= 1'b0;
         r_len   <= '0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_state <= S_GRANT;
                  r_win   <= w_pick;
                  r_gnt   <= w_pick ? 2'b10 : 2'b01;
               end
            end
            S_GRANT: begin
               r_sub   <= req_sub[r_win];
               r_creg  <= req_sub[r_win];
               r_len   <= r_win ? req_len[2*LW-1:LW] : req_len[LW-1:0];
               r_cnt   <= '0;
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (w_fire) begin
                  r_cnt  <= r_cnt + 1'b1;
                  r_creg <= adder_cout;
                  if (w_beat_last) r_state <= S_DRAIN;
               end
            end
            default: begin
               if (w_ofire && r_last) begin
                  r_state <= S_IDLE;
                  r_gnt   <= 2'b00;
                  r_rr    <= ~r_win;
               end
            end
         endcase
      end
   end

   // one-entry result register; a new beat may load while the old one drains
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ov    <= 1'b0;
         r_sum   <= '0;
         r_last  <= 1'b0;
         r_carry <= 1'b0;
      end else if (w_fire) begin
         r_ov    <= 1'b1;
         r_sum   <= adder_sum;
         r_last  <= w_beat_last;
         r_carry <= w_beat_last & (adder_cout ^ r_sub);
      end else if (out_ready) begin
         r_ov    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_csa16_mw_addsub_sched.sv
// Bench for csa16_mw_addsub_sched: directed and random multi-word jobs
// checked against a whole-number add/sub model with a round-robin pointer.
module tb_csa16_mw_addsub_sched;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  req_sub;
   logic [5:0]  req_len;
   logic [1:0]  gnt;
   logic        in_valid;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] out_sum;
   logic        out_last;
   logic        out_carry;
   logic        out_ready;
   logic        busy;
   logic [15:0] adder_a;
   logic [15:0] adder_b;
   logic        adder_cin;
   logic [15:0] adder_sum;
   logic        adder_cout;

   int          n_err;
   int          n_chk;
   bit          rr_m;
   logic [15:0] wa [8];
   logic [15:0] wb [8];
   int          g;

   csa16_mw_addsub_sched dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_sub    (req_sub),
      .req_len    (req_len),
      .gnt        (gnt),
      .in_valid   (in_valid),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_sum    (out_sum),
      .out_last   (out_last),
      .out_carry  (out_carry),
      .out_ready  (out_ready),
      .busy       (busy),
      .adder_a    (adder_a),
      .adder_b    (adder_b),
      .adder_cin  (adder_cin),
      .adder_sum  (adder_sum),
      .adder_cout (adder_cout)
   );

   // external combinational adder
   assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b}
                                    + {16'b0, adder_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input logic [1:0] rq, input logic sub,
                          input int len, input int stall_at,
                          input int stall_n, input bit rnd,
                          input int abort_at, output int gcyc);
      logic [128:0] A, B, R;
      logic         cexp;
      logic [1:0]   wm;
      int           win, sent, got, cyc, nst;
      bit           fired, hold;
      logic [15:0]  hsum;
      A = '0;
      B = '0;
      for (int i = 0; i <= len; i++) begin
         A[i*16 +: 16] = wa[i];
         B[i*16 +: 16] = wb[i];
      end
      if (sub) begin
         R    = A - B;
         cexp = (A < B);
      end else begin
         R    = A + B;
         cexp = R[16*(len+1)];
      end
      win  = (rq == 2'b11) ? int'(rr_m) : int'(rq[1]);
      wm   = 2'(1 << win);
      gcyc = 0;
      chk("idle_gnt", gnt, 0);
      chk("idle_busy", busy, 0);
      req     = rq;
      req_sub = 2'($urandom);
      req_len = 6'($urandom);
      req_sub[win] = sub;
      req_len[win*3 +: 3] = 3'(len);
      in_valid  = 1'b1;
      in_a      = 16'($urandom) | 16'h0001;
      in_b      = 16'($urandom);
      out_ready = 1'b1;
      #1;
      chk("idle_rdy", in_ready, 0);
      @(posedge clk); #1;
      gcyc = 1;
      chk("gnt", gnt, wm);
      chk("g_busy", busy, 1);
      chk("g_rdy", in_ready, 0);
      chk("g_adda", adder_a, 0);
      chk("g_cin", adder_cin, 0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      req     = rq & ~wm;
      req_sub = 2'($urandom);
      req_len = 6'($urandom);
      sent = 0; got = 0; cyc = 0; nst = 0;
      fired = 0; hold = 0; hsum = '0;
      while (got <= len && cyc < 300) begin
         if (gnt != 2'b00) gcyc++;
         if (hold) begin
            chk("hold_v", out_valid, 1);
            chk("hold_sum", out_sum, hsum);
         end
         if (fired) chk("lat_v", out_valid, 1);
         in_valid = (sent <= len);
         if (sent <= len) begin
            in_a = wa[sent];
            in_b = wb[sent];
         end else begin
            in_a = 16'($urandom);
            in_b = 16'($urandom);
         end
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         else begin
            out_ready = !(sent >= stall_at && nst < stall_n && out_valid);
            if (!out_ready) nst++;
         end
         #1;
         if (out_valid && !out_ready) chk("stall_rdy", in_ready, 0);
         else if (sent <= len) chk("run_rdy", in_ready, 1);
         else chk("drain_rdy", in_ready, 0);
         fired = in_valid && in_ready;
         if (out_valid && out_ready) begin
            chk("sum", out_sum, R[got*16 +: 16]);
            chk("last", out_last, (got == len));
            chk("carry", out_carry, (got == len) ? cexp : 1'b0);
            got++;
         end
         hold = out_valid && !out_ready;
         hsum = out_sum;
         if (fired) sent++;
         if (abort_at >= 0 && sent == abort_at) begin
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_busy", busy, 0);
            chk("rst_gnt", gnt, 0);
            chk("rst_ov", out_valid, 0);
            chk("rst_sum", out_sum, 0);
            chk("rst_rdy", in_ready, 0);
            rst      = 1'b0;
            in_valid = 1'b0;
            req      = 2'b00;
            rr_m     = 1'b0;
            return;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("done", got, len + 1);
      in_valid = 1'b0;
      chk("end_ov", out_valid, 0);
      rr_m = (win == 0);
   endtask

   initial begin
      n_err = 0; n_chk = 0; rr_m = 1'b0;
      rst = 1'b1; req = 2'b00; req_sub = 2'b00; req_len = '0;
      in_valid = 1'b1; in_a = 16'hA5A5; in_b = 16'h5A5A; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("r_gnt", gnt, 0);
      chk("r_busy", busy, 0);
      chk("r_ov", out_valid, 0);
      chk("r_sum", out_sum, 0);
      chk("r_last", out_last, 0);
      chk("r_carry", out_carry, 0);
      chk("r_rdy", in_ready, 0);
      chk("r_adda", adder_a, 0);
      chk("r_addb", adder_b, 0);
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;

      wa[0] = 16'hFFFF; wb[0] = 16'h0001;
      run_txn(2'b01, 1'b0, 0, 0, 0, 0, -1, g);
      chk("t1_gcyc", g, 3);

      wa[0] = 16'h0000; wa[1] = 16'h0001;
      wb[0] = 16'h0001; wb[1] = 16'h0000;
      run_txn(2'b10, 1'b1, 1, 0, 0, 0, -1, g);

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) begin
            wa[i] = 16'($urandom); wb[i] = 16'($urandom);
         end
         run_txn(2'b11, 1'(k), 2, 0, 0, 0, -1, g);
      end

      for (int i = 0; i < 8; i++) begin
         wa[i] = 16'hFFFF; wb[i] = 16'($urandom);
      end
      run_txn(2'b01, 1'b0, 3, 2, 3, 0, -1, g);

      run_txn(2'b01, 1'b1, 3, 0, 0, 0, 2, g);
      for (int i = 0; i < 8; i++) begin
         wa[i] = 16'($urandom); wb[i] = 16'($urandom);
      end
      run_txn(2'b10, 1'b0, 3, 0, 0, 0, -1, g);

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 8; i++) begin
            wa[i] = 16'($urandom);
            wb[i] = ($urandom_range(0, 3) == 0) ? wa[i] : 16'($urandom);
         end
         run_txn(2'($urandom_range(1, 3)), 1'($urandom),
                 $urandom_range(0, 7), 0, 0, 1, -1, g);
      end
      chk("fin_gnt", gnt, 0);
      chk("fin_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
